// File: rtl/rsa_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : rsa_pkg                                                    |
// | Brief    : Shared RSA datapath types and default operand sizes.       |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
package rsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH     = 256;
  localparam int DEF_MAX_SHIFT = 256;

endpackage
`default_nettype wire

// File: rtl/mod_shift_preproc_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : mod_shift_preproc_if                                       |
// | Brief    : Request/result handshake bundle of the shift pre-processor.|
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
interface mod_shift_preproc_if
  import rsa_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHIFT_W = 9
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   n;
  logic [SHIFT_W-1:0] shift;
  logic               abort;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out;
  logic               err;
  logic               busy;

  modport master (
    output in_valid, m, n, shift, abort, out_ready,
    input  in_ready, out_valid, out, err, busy
  );

  modport slave (
    input  in_valid, m, n, shift, abort, out_ready,
    output in_ready, out_valid, out, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/mod_double_step.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : mod_double_step                                            |
// | Brief    : Combinational (2r + b) mod n, assuming r < n.              |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module mod_double_step #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] r,
  input  logic             b,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] res
);
  logic [WIDTH:0]   w_t;
  logic             w_ge;
  logic [WIDTH-1:0] w_low;

  // t < 2n, so the true difference always fits in WIDTH bits and the
  // WIDTH-bit wrap-around subtraction gives the exact result.
  assign w_t   = {r, b};
  assign w_ge  = (w_t >= {1'b0, n});
  assign w_low = w_t[WIDTH-1:0];
  assign res   = w_ge ? (w_low - n) : w_low;
endmodule
`default_nettype wire

// File: rtl/mod_shift_preproc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : mod_shift_preproc                                          |
// | Brief    : Bit-serial (m * 2^shift) mod n pre-processor.              |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module mod_shift_preproc
  import rsa_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_SHIFT = DEF_MAX_SHIFT,
  parameter int SHIFT_W   = 9
) (
  input  logic               clk,
  input  logic               reset,
  mod_shift_preproc_if.slave bus
);
  localparam int                 c_cnt_w     = $clog2(WIDTH + MAX_SHIFT + 1);
  localparam logic [SHIFT_W-1:0] c_max_shift = SHIFT_W'(MAX_SHIFT);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH-1:0]   r_n;
  logic [WIDTH-1:0]   r_r;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_out;
  logic               r_err;
  logic [SHIFT_W-1:0] w_shift_sat;
  logic [c_cnt_w-1:0] w_steps;
  logic [WIDTH-1:0]   w_next_r;
  logic               w_last;

  assign w_shift_sat = (bus.shift > c_max_shift) ? c_max_shift : bus.shift;
  assign w_steps     = c_cnt_w'(WIDTH) + c_cnt_w'(w_shift_sat);
  assign w_last      = (r_cnt == c_cnt_w'(1));

  // m is shifted out MSB first; after WIDTH steps it is all zeros, which
  // supplies the b=0 doubling steps for the shift part for free.
  mod_double_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r   (r_r),
    .b   (r_m[WIDTH-1]),
    .n   (r_n),
    .res (w_next_r)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = (bus.n == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        bus.busy = 1'b1;
        if (bus.abort) begin
          w_state_next = ST_IDLE;
        end else if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        bus.busy      = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m   <= '0;
      r_n   <= '0;
      r_r   <= '0;
      r_cnt <= '0;
      r_out <= '0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            r_m   <= bus.m;
            r_n   <= bus.n;
            r_r   <= '0;
            r_cnt <= w_steps;
            if (bus.n == '0) begin
              r_out <= '0;
              r_err <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (!bus.abort) begin
            r_r   <= w_next_r;
            r_m   <= r_m << 1;
            r_cnt <= r_cnt - c_cnt_w'(1);
            if (w_last) begin
              r_out <= w_next_r;
              r_err <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out = r_out;
  assign bus.err = r_err;
endmodule
`default_nettype wire

// File: tb/tb_mod_shift_preproc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module   : tb_mod_shift_preproc                                       |
// | Brief    : Self-checking bench, 8-bit and 256-bit instances.          |
// | Revision : 1.0                                                        |
// +-----------------------------------------------------------------------+
module tb_mod_shift_preproc;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mod_shift_preproc_if #(.WIDTH(8),   .SHIFT_W(5)) b8 ();
  mod_shift_preproc_if #(.WIDTH(256), .SHIFT_W(9)) b256 ();

  mod_shift_preproc #(.WIDTH(8), .MAX_SHIFT(8), .SHIFT_W(5)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8)
  );

  mod_shift_preproc #(.WIDTH(256), .MAX_SHIFT(256), .SHIFT_W(9)) u_dut256 (
    .clk   (clk),
    .reset (reset),
    .bus   (b256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref8(input logic [7:0] mm, input logic [7:0] nn, input int sh);
    logic [63:0] p;
    int          sat;
    if (nn == 8'd0) return 8'd0;
    sat = (sh > 8) ? 8 : sh;
    p = 64'(mm) << sat;
    return 8'(p % 64'(nn));
  endfunction

  function automatic logic [255:0] ref256(input logic [255:0] mm, input logic [255:0] nn, input int sh);
    logic [257:0] x;
    int           sat;
    if (nn == '0) return '0;
    sat = (sh > 256) ? 256 : sh;
    x = {2'b00, mm} % {2'b00, nn};
    for (int k = 0; k < sat; k++) x = (x << 1) % {2'b00, nn};
    return x[255:0];
  endfunction

  // Caller is positioned 1 time unit after a rising edge with the DUT idle.
  task automatic do_job8(input logic [7:0] mm, input logic [7:0] nn, input int sh, input string tag);
    logic [7:0] exp_out;
    int         exp_lat;
    int         lat;
    exp_out = ref8(mm, nn, sh);
    exp_lat = (nn == 8'd0) ? 0 : 8 + ((sh > 8) ? 8 : sh);
    b8.m = mm; b8.n = nn; b8.shift = 5'(sh); b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    lat = 0;
    while (b8.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
    end
    checks++;
    if (b8.out !== exp_out || b8.err !== (nn == 8'd0)) begin
      errors++; $display("FAIL %s result: got out=%0d err=%b want out=%0d err=%b", tag, b8.out, b8.err, exp_out, (nn == 8'd0));
    end
    checks++;
    if (b8.in_ready !== 1'b0 || b8.busy !== 1'b1) begin
      errors++; $display("FAIL %s done flags: got in_ready=%b busy=%b want 0 1", tag, b8.in_ready, b8.busy);
    end
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    checks++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.busy !== 1'b0) begin
      errors++; $display("FAIL %s release: got in_ready=%b out_valid=%b busy=%b want 1 0 0", tag, b8.in_ready, b8.out_valid, b8.busy);
    end
  endtask

  task automatic do_job256(input logic [255:0] mm, input logic [255:0] nn, input int sh, input string tag);
    logic [255:0] exp_out;
    int           exp_lat;
    int           lat;
    exp_out = ref256(mm, nn, sh);
    exp_lat = (nn == '0) ? 0 : 256 + ((sh > 256) ? 256 : sh);
    b256.m = mm; b256.n = nn; b256.shift = 9'(sh); b256.in_valid = 1'b1;
    @(posedge clk); #1;
    b256.in_valid = 1'b0;
    lat = 0;
    while (b256.out_valid !== 1'b1 && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat != exp_lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", tag, lat, exp_lat);
    end
    checks++;
    if (b256.out !== exp_out || b256.err !== (nn == '0)) begin
      errors++; $display("FAIL %s result: got out=%h err=%b want out=%h", tag, b256.out, b256.err, exp_out);
    end
    b256.out_ready = 1'b1;
    @(posedge clk); #1;
    b256.out_ready = 1'b0;
    checks++;
    if (b256.in_ready !== 1'b1 || b256.out_valid !== 1'b0) begin
      errors++; $display("FAIL %s release: got in_ready=%b out_valid=%b want 1 0", tag, b256.in_ready, b256.out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    b8.in_valid = 1'b0;   b8.m = '0;   b8.n = '0;   b8.shift = '0;   b8.abort = 1'b0;   b8.out_ready = 1'b0;
    b256.in_valid = 1'b0; b256.m = '0; b256.n = '0; b256.shift = '0; b256.abort = 1'b0; b256.out_ready = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.out !== 8'd0 || b8.err !== 1'b0 || b8.busy !== 1'b0) begin
      errors++; $display("FAIL reset8: got rdy=%b vld=%b out=%0d err=%b busy=%b want 1 0 0 0 0", b8.in_ready, b8.out_valid, b8.out, b8.err, b8.busy);
    end
    checks++;
    if (b256.in_ready !== 1'b1 || b256.out_valid !== 1'b0 || b256.out !== '0 || b256.err !== 1'b0 || b256.busy !== 1'b0) begin
      errors++; $display("FAIL reset256: got rdy=%b vld=%b err=%b busy=%b want 1 0 0 0", b256.in_ready, b256.out_valid, b256.err, b256.busy);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed8();
    do_job8(8'd200, 8'd13,  8,  "m200_n13_s8");
    do_job8(8'd200, 8'd13,  0,  "m200_n13_s0");
    do_job8(8'd200, 8'd13,  20, "shift_saturate");
    do_job8(8'd77,  8'd1,   3,  "n_one");
    do_job8(8'd255, 8'd255, 5,  "m_eq_n");
    do_job8(8'd9,   8'd0,   4,  "div_zero");
    do_job8(8'd3,   8'd5,   2,  "after_div_zero");
  endtask

  task automatic test_random8();
    logic [7:0] mm;
    logic [7:0] nn;
    for (int k = 0; k < 40; k++) begin
      mm = 8'($urandom);
      nn = (k % 10 == 0) ? 8'd0 : 8'($urandom);
      do_job8(mm, nn, int'($urandom_range(0, 31)), "rand8");
    end
  endtask

  task automatic test_wide();
    logic [255:0] mm;
    logic [255:0] nn;
    do_job256(256'd5, 256'd7, 256, "w_m5_n7_s256");
    mm = '0; mm[255] = 1'b1; mm[0] = 1'b1;
    nn = '0; nn[255] = 1'b1;
    do_job256(mm, nn, 0, "w_top_bit");
    for (int k = 0; k < 3; k++) begin
      for (int w = 0; w < 8; w++) begin
        mm[w*32 +: 32] = $urandom;
        nn[w*32 +: 32] = $urandom;
      end
      if (k == 1) nn = nn >> 200;
      nn[0] = 1'b1;
      do_job256(mm, nn, int'($urandom_range(0, 300)), "rand256");
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_out;
    int         lat;
    exp_out = ref8(8'd200, 8'd13, 8);
    b8.m = 8'd200; b8.n = 8'd13; b8.shift = 5'd8; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    lat = 0;
    while (b8.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    for (int c = 0; c < 5; c++) begin
      b8.in_valid = 1'b1; b8.m = 8'd1; b8.n = 8'd3; b8.shift = 5'd1;
      b8.abort = (c == 2);
      @(posedge clk); #1;
      checks++;
      if (b8.out_valid !== 1'b1 || b8.out !== exp_out || b8.err !== 1'b0 || b8.in_ready !== 1'b0) begin
        errors++; $display("FAIL hold cycle %0d: got vld=%b out=%0d err=%b rdy=%b want 1 %0d 0 0", c, b8.out_valid, b8.out, b8.err, b8.in_ready, exp_out);
      end
    end
    b8.in_valid = 1'b0; b8.abort = 1'b0; b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
    checks++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0) begin
      errors++; $display("FAIL hold release: got rdy=%b vld=%b want 1 0", b8.in_ready, b8.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (b8.busy !== 1'b0 || b8.in_ready !== 1'b1) begin
      errors++; $display("FAIL hold no_capture: got busy=%b rdy=%b want 0 1", b8.busy, b8.in_ready);
    end
  endtask

  task automatic test_abort();
    int seen;
    int lat;
    b8.m = 8'd200; b8.n = 8'd13; b8.shift = 5'd8; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    b8.abort = 1'b1;
    @(posedge clk); #1;
    b8.abort = 1'b0;
    checks++;
    if (b8.in_ready !== 1'b1 || b8.busy !== 1'b0 || b8.out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_run: got rdy=%b busy=%b vld=%b want 1 0 0", b8.in_ready, b8.busy, b8.out_valid);
    end
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (b8.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL abort_no_result: got %0d valid cycles want 0", seen);
    end
    // abort while idle must not block an accept
    b8.m = 8'd3; b8.n = 8'd5; b8.shift = 5'd2; b8.in_valid = 1'b1; b8.abort = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0; b8.abort = 1'b0;
    checks++;
    if (b8.busy !== 1'b1) begin
      errors++; $display("FAIL abort_idle: got busy=%b want 1", b8.busy);
    end
    lat = 0;
    while (b8.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (b8.out !== ref8(8'd3, 8'd5, 2) || lat != 10) begin
      errors++; $display("FAIL abort_idle_result: got out=%0d lat=%0d want %0d 10", b8.out, lat, ref8(8'd3, 8'd5, 2));
    end
    b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    b8.m = 8'd200; b8.n = 8'd13; b8.shift = 5'd8; b8.in_valid = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.out !== 8'd0 || b8.err !== 1'b0 || b8.busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_run: got rdy=%b vld=%b out=%0d err=%b busy=%b want 1 0 0 0 0", b8.in_ready, b8.out_valid, b8.out, b8.err, b8.busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    do_job8(8'd3, 8'd5, 2, "after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_directed8();
    test_random8();
    test_wide();
    test_backpressure();
    test_abort();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
